// File: rtl/datapath_seq_if.sv
// Host-side bundle of datapath_seq: op issue handshake, host register port and observation outputs.
interface datapath_seq_if #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
);
    localparam int AW = $clog2(NREGS);

    logic             start;
    logic [3:0]       op;
    logic [AW-1:0]    ra, rb, rc;
    logic             use_imm;
    logic [WIDTH-1:0] imm;
    logic             ld_en;
    logic [AW-1:0]    ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic [AW-1:0]    rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             busy, done, err;
    logic [WIDTH-1:0] hi, lo, bus_mon;

    modport master (
        output start, op, ra, rb, rc, use_imm, imm, ld_en, ld_addr, ld_data, rd_addr,
        input  rd_data, busy, done, err, hi, lo, bus_mon
    );
    modport slave (
        input  start, op, ra, rb, rc, use_imm, imm, ld_en, ld_addr, ld_data, rd_addr,
        output rd_data, busy, done, err, hi, lo, bus_mon
    );
endinterface

// File: rtl/datapath_seq.sv
// Single-bus register-file datapath with a T3..T6 step sequencer driven by a start/done handshake.
// Optional feature macro DP_MUL_EN: enables op 9 (signed MUL, extra T6 step writing HI).
module datapath_seq #(
    parameter int WIDTH = 32,
    parameter int NREGS = 16
) (
    input  logic           clk,
    input  logic           clr,
    datapath_seq_if.slave  dp
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(WIDTH);

    if (WIDTH < 8 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("datapath_seq: WIDTH must be a power of two >= 8");
    end
    if (NREGS < 2 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_nregs
        $error("datapath_seq: NREGS must be a power of two >= 2");
    end

    typedef enum logic [2:0] {IDLE, T3, T4, T5, T6} state_t;

    typedef struct packed {
        logic [3:0]       op;
        logic [AW-1:0]    ra;
        logic [AW-1:0]    rb;
        logic [AW-1:0]    rc;
        logic             use_imm;
        logic [WIDTH-1:0] imm;
    } instr_t;

    state_t                      state, state_nx;
    instr_t                      ir;
    logic [NREGS-1:0][WIDTH-1:0] rf;
    logic [WIDTH-1:0]            y, hi, lo, bus, b_opnd;
    logic [2*WIDTH-1:0]          z, alu;
    logic [SW-1:0]               shamt;
    logic                        done_q, err_q;
    logic                        start_ok, start_bad, is_mul;
    logic                        y_we, z_we, rf_we, lo_we, hi_we, fin;

    function automatic logic legal(input logic [3:0] o);
`ifdef DP_MUL_EN
        return o <= 4'd10;
`else
        return (o <= 4'd10) && (o != 4'd9);
`endif
    endfunction

`ifdef DP_MUL_EN
    assign is_mul = (ir.op == 4'd9);
`else
    assign is_mul = 1'b0;
`endif

    assign start_ok  = (state == IDLE) && dp.start &&  legal(dp.op);
    assign start_bad = (state == IDLE) && dp.start && !legal(dp.op);
    assign b_opnd    = ir.use_imm ? ir.imm : rf[ir.rc];
    assign shamt     = bus[SW-1:0];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_ok) state_nx = T3;
            T3:      state_nx = T4;
            T4:      state_nx = T5;
            T5:      state_nx = is_mul ? T6 : IDLE;
            T6:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // One bus driver per step; the bus idles at zero so bus_mon reads 0 in IDLE.
    always_comb begin
        bus   = '0;
        y_we  = 1'b0;
        z_we  = 1'b0;
        rf_we = 1'b0;
        lo_we = 1'b0;
        hi_we = 1'b0;
        fin   = 1'b0;
        case (state)
            T3: begin bus = rf[ir.rb]; y_we = 1'b1; end
            T4: begin bus = b_opnd;    z_we = 1'b1; end
            T5: begin
                bus   = z[WIDTH-1:0];
                rf_we = !is_mul;
                lo_we = is_mul;
                fin   = !is_mul;
            end
            T6: begin bus = z[2*WIDTH-1:WIDTH]; hi_we = 1'b1; fin = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        alu = '0;
        case (ir.op)
            4'd0:  alu[WIDTH-1:0] = y + bus;
            4'd1:  alu[WIDTH-1:0] = y - bus;
            4'd2:  alu[WIDTH-1:0] = y & bus;
            4'd3:  alu[WIDTH-1:0] = y | bus;
            4'd4:  alu[WIDTH-1:0] = y << shamt;
            4'd5:  alu[WIDTH-1:0] = y >> shamt;
            4'd6:  alu[WIDTH-1:0] = $signed(y) >>> shamt;
            4'd7:  alu[WIDTH-1:0] = ~y;
            4'd8:  alu[WIDTH-1:0] = '0 - y;
`ifdef DP_MUL_EN
            4'd9:  alu = $signed({{WIDTH{y[WIDTH-1]}}, y}) * $signed({{WIDTH{bus[WIDTH-1]}}, bus});
`endif
            4'd10: alu[WIDTH-1:0] = bus;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            rf     <= '0;
            y      <= '0;
            z      <= '0;
            hi     <= '0;
            lo     <= '0;
            ir     <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= fin | start_bad;
            err_q  <= start_bad;
            if (start_ok)
                ir <= '{op: dp.op, ra: dp.ra, rb: dp.rb, rc: dp.rc,
                        use_imm: dp.use_imm, imm: dp.imm};
            // Host load shares the accept edge, so T3/T4 already see it.
            if (state == IDLE && dp.ld_en) rf[dp.ld_addr] <= dp.ld_data;
            if (rf_we) rf[ir.ra] <= bus;
            if (y_we)  y  <= bus;
            if (z_we)  z  <= alu;
            if (lo_we) lo <= bus;
            if (hi_we) hi <= bus;
        end
    end

    assign dp.rd_data = rf[dp.rd_addr];
    assign dp.busy    = (state != IDLE);
    assign dp.done    = done_q;
    assign dp.err     = err_q;
    assign dp.hi      = hi;
    assign dp.lo      = lo;
    assign dp.bus_mon = bus;
endmodule

// File: tb/tb_datapath_seq.sv
// Bench for datapath_seq: constant vector table, hand-written corner sequences, randomized ops vs. a reference model.
module tb_datapath_seq;
    localparam int W = 32;
    localparam int N = 16;

`ifdef DP_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    datapath_seq_if #(.WIDTH(W), .NREGS(N)) dif ();
    datapath_seq #(.WIDTH(W), .NREGS(N)) dut (.clk(clk), .clr(clr), .dp(dif));

    int n_chk  = 0;
    int n_fail = 0;

    logic [W-1:0] ref_rf [N];
    logic [W-1:0] ref_hi, ref_lo;
    logic [W-1:0] bm [5];
    int           lat;
    logic         got_err;

    typedef struct {
        logic [3:0]   op, ra, rb, rc;
        logic         ui;
        logic [W-1:0] imm, a, b, er;
        int           el;
        logic         ee;
        logic [W-1:0] ehi, elo;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [4:0]   s;
        logic [W-1:0] r;
        longint       p;
        s = b[4:0];
        r = '0;
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a << s;
            4'd5:  r = a >> s;
            4'd6:  r = (a >> s) | (a[W-1] ? ~({W{1'b1}} >> s) : '0);
            4'd7:  r = ~a;
            4'd8:  r = 32'd0 - a;
            4'd9:  begin p = longint'($signed(a)) * longint'($signed(b)); return p; end
            4'd10: r = b;
            default: r = '0;
        endcase
        return {32'd0, r};
    endfunction

    task automatic idle_inputs;
        dif.start = 0; dif.op = 0; dif.ra = 0; dif.rb = 0; dif.rc = 0;
        dif.use_imm = 0; dif.imm = 0; dif.ld_en = 0; dif.ld_addr = 0;
        dif.ld_data = 0; dif.rd_addr = 0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [W-1:0] d);
        dif.rd_addr = a;
        #1;
        d = dif.rd_data;
    endtask

    task automatic load(input logic [3:0] a, input logic [W-1:0] d);
        @(negedge clk);
        dif.ld_en = 1; dif.ld_addr = a; dif.ld_data = d;
        @(negedge clk);
        dif.ld_en = 0;
        ref_rf[a] = d;
    endtask

    // Issues one op (optionally with a same-cycle host load), waits for done, updates the model.
    task automatic exec(input logic [3:0] op, input logic [3:0] ra, input logic [3:0] rb,
                        input logic [3:0] rc, input logic ui, input logic [W-1:0] imm,
                        input bit ld, input logic [3:0] ld_a, input logic [W-1:0] ld_d,
                        input bit chk);
        logic [W-1:0] a, b, v;
        logic [63:0]  r;
        bit           legal;
        int           el;
        if (ld) ref_rf[ld_a] = ld_d;
        a = ref_rf[rb];
        b = ui ? imm : ref_rf[rc];
        r = model(op, a, b);
        legal = (op <= 4'd10) && (op != 4'd9 || MUL_EN);
        el = !legal ? 0 : (op == 4'd9 ? 4 : 3);
        @(negedge clk);
        dif.op = op; dif.ra = ra; dif.rb = rb; dif.rc = rc; dif.use_imm = ui; dif.imm = imm;
        dif.start = 1;
        if (ld) begin dif.ld_en = 1; dif.ld_addr = ld_a; dif.ld_data = ld_d; end
        @(negedge clk);
        dif.start = 0;
        dif.ld_en = 0;
        lat = -1;
        got_err = 0;
        for (int i = 0; i < 5; i++) bm[i] = '0;
        for (int k = 1; k <= 8; k++) begin
            if (k <= 5) bm[k-1] = dif.bus_mon;
            if (dif.done) begin
                lat = k - 1;
                got_err = dif.err;
                break;
            end
            @(negedge clk);
        end
        if (legal) begin
            if (op == 4'd9) begin ref_lo = r[31:0]; ref_hi = r[63:32]; end
            else ref_rf[ra] = r[31:0];
        end
        if (chk) begin
            check($sformatf("rnd op%0d latency", op), lat, el);
            check($sformatf("rnd op%0d err", op), got_err, !legal);
            if (legal) begin
                check($sformatf("rnd op%0d bus T3", op), bm[0], a);
                check($sformatf("rnd op%0d bus T4", op), bm[1], b);
                check($sformatf("rnd op%0d bus T5", op), bm[2], r[31:0]);
            end
            rd(ra, v);
            check($sformatf("rnd op%0d R%0d", op, ra), v, ref_rf[ra]);
            check("rnd hi", dif.hi, ref_hi);
            check("rnd lo", dif.lo, ref_lo);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        vec_t         tv [16];
        logic [W-1:0] v;
        int           cnt;

        idle_inputs();
        for (int i = 0; i < N; i++) ref_rf[i] = '0;
        ref_hi = '0;
        ref_lo = '0;

        // Reset state
        #12;
        check("reset busy", dif.busy, 0);
        check("reset done", dif.done, 0);
        check("reset bus_mon", dif.bus_mon, 0);
        clr = 1;
        @(negedge clk);
        check("reset err", dif.err, 0);
        check("reset hi", dif.hi, 0);
        check("reset lo", dif.lo, 0);
        rd(4'd9, v);
        check("reset R9", v, 0);

        //        op     ra     rb     rc     ui  imm            a              b              er             el  ee  ehi  elo
        tv[0]  = '{4'd0, 4'd1,  4'd2,  4'd3,  0, 32'h0,         32'd5,         32'd7,         32'd12,        3, 0, 0, 0};
        tv[1]  = '{4'd1, 4'd4,  4'd2,  4'd3,  0, 32'h0,         32'd5,         32'd7,         32'hFFFFFFFE,  3, 0, 0, 0};
        tv[2]  = '{4'd0, 4'd5,  4'd2,  4'd3,  0, 32'h0,         32'hFFFFFFFF,  32'd2,         32'd1,         3, 0, 0, 0};
        tv[3]  = '{4'd2, 4'd7,  4'd8,  4'd9,  0, 32'h0,         32'hF0F01234,  32'h0FF0FF00,  32'h00F01200,  3, 0, 0, 0};
        tv[4]  = '{4'd3, 4'd7,  4'd8,  4'd9,  0, 32'h0,         32'hF0F01234,  32'h0FF0FF00,  32'hFFF0FF34,  3, 0, 0, 0};
        tv[5]  = '{4'd6, 4'd6,  4'd5,  4'd0,  1, 32'd4,         32'h80000000,  32'h0,         32'hF8000000,  3, 0, 0, 0};
        tv[6]  = '{4'd6, 4'd6,  4'd5,  4'd0,  1, 32'd8,         32'h7F000000,  32'h0,         32'h007F0000,  3, 0, 0, 0};
        tv[7]  = '{4'd4, 4'd10, 4'd11, 4'd0,  1, 32'd36,        32'h000000F1,  32'h0,         32'h00000F10,  3, 0, 0, 0};
        tv[8]  = '{4'd5, 4'd12, 4'd11, 4'd0,  1, 32'd31,        32'h80000001,  32'h0,         32'h00000001,  3, 0, 0, 0};
        tv[9]  = '{4'd7, 4'd13, 4'd14, 4'd0,  1, 32'h0,         32'h0000FFFF,  32'h0,         32'hFFFF0000,  3, 0, 0, 0};
        tv[10] = '{4'd8, 4'd15, 4'd14, 4'd0,  1, 32'h0,         32'd1,         32'h0,         32'hFFFFFFFF,  3, 0, 0, 0};
        tv[11] = '{4'd10, 4'd0, 4'd2,  4'd3,  0, 32'h0,         32'd5,         32'd7,         32'd7,         3, 0, 0, 0};
        tv[12] = '{4'd10, 4'd0, 4'd2,  4'd3,  1, 32'h1234ABCD,  32'd5,         32'd7,         32'h1234ABCD,  3, 0, 0, 0};
        tv[13] = '{4'd15, 4'd1, 4'd2,  4'd3,  0, 32'h0,         32'd5,         32'd7,         32'hDEADBEEF,  0, 1, 0, 0};
        tv[14] = '{4'd11, 4'd1, 4'd2,  4'd3,  0, 32'h0,         32'd5,         32'd7,         32'hDEADBEEF,  0, 1, 0, 0};
        tv[15] = '{4'd9,  4'd1, 4'd2,  4'd3,  0, 32'h0,         32'hFFFFFFFD,  32'd7,         32'hDEADBEEF,
                   MUL_EN ? 4 : 0, !MUL_EN, MUL_EN ? 32'hFFFFFFFF : 32'h0, MUL_EN ? 32'hFFFFFFEB : 32'h0};

        for (int i = 0; i < 16; i++) begin
            load(tv[i].ra, 32'hDEADBEEF);
            load(tv[i].rb, tv[i].a);
            if (!tv[i].ui) load(tv[i].rc, tv[i].b);
            exec(tv[i].op, tv[i].ra, tv[i].rb, tv[i].rc, tv[i].ui, tv[i].imm, 0, 0, 0, 0);
            check($sformatf("vec%0d latency", i), lat, tv[i].el);
            check($sformatf("vec%0d err", i), got_err, tv[i].ee);
            check($sformatf("vec%0d busy at done", i), dif.busy, 0);
            rd(tv[i].ra, v);
            check($sformatf("vec%0d R%0d", i, tv[i].ra), v, tv[i].er);
            if (!tv[i].ee) begin
                check($sformatf("vec%0d bus T3", i), bm[0], tv[i].a);
                check($sformatf("vec%0d bus T4", i), bm[1], tv[i].ui ? tv[i].imm : tv[i].b);
                check($sformatf("vec%0d bus T5", i), bm[2], tv[i].op == 4'd9 ? tv[i].elo : tv[i].er);
                if (tv[i].op == 4'd9) check($sformatf("vec%0d bus T6", i), bm[3], tv[i].ehi);
            end else begin
                check($sformatf("vec%0d bus idle", i), bm[0], 0);
            end
            if (tv[i].op == 4'd9) begin
                check($sformatf("vec%0d hi", i), dif.hi, tv[i].ehi);
                check($sformatf("vec%0d lo", i), dif.lo, tv[i].elo);
            end
        end

        // start held high through a running R2 = R2 + R3: a re-execution would change R2 again
        load(4'd2, 32'd5);
        load(4'd3, 32'd7);
        @(negedge clk);
        dif.op = 4'd0; dif.ra = 4'd2; dif.rb = 4'd2; dif.rc = 4'd3; dif.use_imm = 0;
        dif.start = 1;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (dif.done) begin cnt++; dif.start = 0; end
        end
        dif.start = 0;
        ref_rf[2] = 32'd12;
        check("held start done count", cnt, 1);
        rd(4'd2, v);
        check("held start R2", v, 32'd12);

        // load and start in the same IDLE cycle
        load(4'd2, 32'd5);
        exec(4'd0, 4'd1, 4'd2, 4'd3, 0, 0, 1, 4'd3, 32'd9, 1);
        rd(4'd1, v);
        check("ld+start R1", v, 32'd14);

        // host load while busy is dropped
        load(4'd7, 32'h0000AAAA);
        @(negedge clk);
        dif.op = 4'd0; dif.ra = 4'd4; dif.rb = 4'd2; dif.rc = 4'd3; dif.use_imm = 0;
        dif.start = 1;
        @(negedge clk);
        dif.start = 0;
        dif.ld_en = 1; dif.ld_addr = 4'd7; dif.ld_data = 32'h55;
        @(negedge clk);
        dif.ld_en = 0;
        cnt = 0;
        for (int k = 0; k < 8 && !dif.done; k++) @(negedge clk);
        check("busy-load done seen", dif.done, 1);
        ref_rf[4] = 32'd14;
        rd(4'd7, v);
        check("busy-load R7", v, 32'h0000AAAA);
        rd(4'd4, v);
        check("busy-load R4", v, 32'd14);

        // randomized ops against the model
        for (int i = 0; i < N; i++) load(4'(i), $urandom);
        for (int i = 0; i < 60; i++) begin
            bit ld;
            if ($urandom_range(0, 3) == 0) load(4'($urandom_range(0, 15)), $urandom);
            ld = ($urandom_range(0, 7) == 0);
            exec(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), $urandom,
                 ld, 4'($urandom_range(0, 15)), $urandom, 1);
        end

        // abort: clr during T4 of an ADD into R1
        load(4'd1, 32'h12345678);
        load(4'd2, 32'd5);
        load(4'd3, 32'd7);
        @(negedge clk);
        dif.op = 4'd0; dif.ra = 4'd1; dif.rb = 4'd2; dif.rc = 4'd3; dif.use_imm = 0;
        dif.start = 1;
        @(negedge clk);
        dif.start = 0;
        @(negedge clk);
        check("abort in T4 busy", dif.busy, 1);
        clr = 0;
        #1;
        check("abort busy", dif.busy, 0);
        check("abort bus_mon", dif.bus_mon, 0);
        @(negedge clk);
        clr = 1;
        cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (dif.done || dif.err || dif.busy) cnt++;
        end
        check("abort no done/busy", cnt, 0);
        check("abort hi", dif.hi, 0);
        check("abort lo", dif.lo, 0);
        cnt = 0;
        for (int i = 0; i < N; i++) begin
            rd(4'(i), v);
            if (v !== '0) cnt++;
        end
        check("abort regs nonzero count", cnt, 0);
        rd(4'd1, v);
        check("abort R1", v, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
